// File: rtl/startup_seq.sv
// Power-up / re-lock sequencer: releases USB FIFO interface reset, then core
// reset, then pulses the configuration start and reports sys_ready in RUN.
// Timeouts retry up to MAX_RETRY times before latching FAULT until rst.
module startup_seq #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       n_ready,
  input  logic       usb_clk_lock,
  input  logic       usb_if_ready,
  input  logic       cfg_done,
  output logic       usb_if_rst,
  output logic       core_rst,
  output logic       cfg_start,
  output logic       sys_ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_USB  = 3'd1,
    WAIT_USB = 3'd2,
    RST_CORE = 3'd3,
    CFG      = 3'd4,
    RUN      = 3'd5,
    FAULT    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             usb_if_rst_q, usb_if_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             cfg_start_q, cfg_start_d;
  logic             sys_ready_q, sys_ready_d;
  logic             fault_q, fault_d;
  logic             timeout;
  logic             go;

  assign go = ~n_ready & usb_clk_lock;

  // Next state, counter and retry bookkeeping; registered outputs follow state_d
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    timeout = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go) state_d = RST_USB;
      end
      RST_USB: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_USB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_USB: begin
        if (usb_if_ready) begin
          state_d = RST_CORE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RST_CORE: begin
        if (cnt_q == RST_LAST) begin
          state_d = CFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CFG: begin
        // cfg_start_q marks the first CFG clock, on which cfg_done is ignored
        if (!cfg_start_q && cfg_done) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN:     cnt_d = '0;
      FAULT:   cnt_d = '0;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (timeout) begin
      cnt_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 2'd1;
        state_d = IDLE;
      end else begin
        state_d = FAULT;
      end
    end

    // Abort overrides every other transition and leaves retry_cnt untouched
    if (!go && (state_q == RST_USB || state_q == WAIT_USB || state_q == RST_CORE ||
                state_q == CFG || state_q == RUN)) begin
      state_d = IDLE;
      cnt_d   = '0;
      retry_d = retry_q;
    end

    usb_if_rst_d = (state_d == IDLE) || (state_d == RST_USB) || (state_d == FAULT);
    core_rst_d   = !((state_d == CFG) || (state_d == RUN));
    cfg_start_d  = (state_q == RST_CORE) && (state_d == CFG);
    sys_ready_d  = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      usb_if_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      cfg_start_q  <= 1'b0;
      sys_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      usb_if_rst_q <= usb_if_rst_d;
      core_rst_q   <= core_rst_d;
      cfg_start_q  <= cfg_start_d;
      sys_ready_q  <= sys_ready_d;
      fault_q      <= fault_d;
    end
  end

  assign usb_if_rst = usb_if_rst_q;
  assign core_rst   = core_rst_q;
  assign cfg_start  = cfg_start_q;
  assign sys_ready  = sys_ready_q;
  assign fault      = fault_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_startup_seq.sv
// Self-checking bench for startup_seq: expected output snapshots are queued
// with the edge at which they must hold and compared on the falling edge.
module tb_startup_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       n_ready;
  logic       usb_clk_lock;
  logic       usb_if_ready;
  logic       cfg_done;
  logic       usb_if_rst;
  logic       core_rst;
  logic       cfg_start;
  logic       sys_ready;
  logic       fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  typedef struct {
    int unsigned at;
    string       tag;
    logic [9:0]  vec;
  } exp_t;

  exp_t sb[$];

  startup_seq #(.TIMEOUT(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .n_ready      (n_ready),
    .usb_clk_lock (usb_clk_lock),
    .usb_if_ready (usb_if_ready),
    .cfg_done     (cfg_done),
    .usb_if_rst   (usb_if_rst),
    .core_rst     (core_rst),
    .cfg_start    (cfg_start),
    .sys_ready    (sys_ready),
    .fault        (fault),
    .state        (state),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected output vector {state, retry, usb_if_rst, core_rst, cfg_start, sys_ready, fault}
  function automatic logic [9:0] mk(input logic [2:0] st, input logic [1:0] r, input logic cs);
    logic uir, cr, sr, f;
    uir = (st == 3'd0) || (st == 3'd1) || (st == 3'd7);
    cr  = (st <= 3'd3) || (st == 3'd7);
    sr  = (st == 3'd5);
    f   = (st == 3'd7);
    return {st, r, uir, cr, cs, sr, f};
  endfunction

  // Queue an expectation k rising edges from now, kept sorted by edge
  task automatic expect_at(input int unsigned k, input string tag, input logic [2:0] st,
                           input logic [1:0] r, input logic cs = 1'b0);
    exp_t e;
    int unsigned idx;
    e.at  = cyc + k;
    e.tag = tag;
    e.vec = mk(st, r, cs);
    idx   = sb.size();
    for (int unsigned i = 0; i < sb.size(); i++) begin
      if (sb[i].at > e.at) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  // Full bring-up from the edge e0 at which IDLE samples go
  task automatic push_seq(input int unsigned e0, input logic [1:0] r);
    expect_at(e0,      "rst_usb",      3'd1, r);
    expect_at(e0 + 15, "rst_usb_end",  3'd1, r);
    expect_at(e0 + 16, "wait_usb",     3'd2, r);
    expect_at(e0 + 17, "rst_core",     3'd3, r);
    expect_at(e0 + 32, "rst_core_end", 3'd3, r);
    expect_at(e0 + 33, "cfg_first",    3'd4, r, 1'b1);
    expect_at(e0 + 34, "cfg_second",   3'd4, r, 1'b0);
    expect_at(e0 + 35, "run_entry",    3'd5, 2'd0);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: pop every expectation due at this edge and compare
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check_eq(e.tag, {22'd0, state, retry_cnt, usb_if_rst, core_rst, cfg_start, sys_ready, fault},
               {22'd0, e.vec});
    end
  end

  initial begin
    rst = 1'b1; n_ready = 1'b1; usb_clk_lock = 1'b0; usb_if_ready = 1'b0; cfg_done = 1'b0;
    tick(4);
    expect_at(1, "reset", 3'd0, 2'd0);
    tick(1);

    // T1: normal bring-up, cfg_done pulsed on the second CFG clock
    rst = 1'b0; n_ready = 1'b0; usb_clk_lock = 1'b1; usb_if_ready = 1'b1;
    push_seq(1, 2'd0);
    tick(35);
    cfg_done = 1'b1;
    tick(1);
    cfg_done = 1'b0;
    expect_at(4, "run_hold", 3'd5, 2'd0);
    tick(5);

    // T2: one-clock lock loss in RUN, then restart with cfg_done held (T6)
    usb_clk_lock = 1'b0;
    expect_at(1, "lock_loss", 3'd0, 2'd0);
    tick(1);
    usb_clk_lock = 1'b1; cfg_done = 1'b1;
    push_seq(1, 2'd0);
    expect_at(38, "run_hold2", 3'd5, 2'd0);
    tick(40);
    cfg_done = 1'b0;

    // T3: usb_if_ready stuck low, three retries then FAULT
    rst = 1'b1;
    expect_at(1, "rst_from_run", 3'd0, 2'd0);
    tick(1);
    rst = 1'b0; usb_if_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      expect_at(1 + 67 * i,  "t3_rst_usb",   3'd1, 2'(i));
      expect_at(17 + 67 * i, "t3_wait",      3'd2, 2'(i));
      expect_at(66 + 67 * i, "t3_wait_last", 3'd2, 2'(i));
      if (i < 3) expect_at(67 + 67 * i, "t3_retry", 3'd0, 2'(i + 1));
      else       expect_at(67 + 67 * i, "t3_fault", 3'd7, 2'd3);
    end
    tick(268);
    for (int unsigned j = 1; j <= 10; j++) expect_at(j, "fault_hold", 3'd7, 2'd3);
    for (int unsigned j = 0; j < 10; j++) begin
      n_ready      = 1'($urandom_range(0, 1));
      usb_clk_lock = 1'($urandom_range(0, 1));
      usb_if_ready = 1'($urandom_range(0, 1));
      cfg_done     = 1'($urandom_range(0, 1));
      tick(1);
    end
    rst = 1'b1;
    expect_at(1, "fault_clr", 3'd0, 2'd0);
    tick(1);

    // T4: first attempt times out, second succeeds
    rst = 1'b0; n_ready = 1'b0; usb_clk_lock = 1'b1; usb_if_ready = 1'b0; cfg_done = 1'b1;
    expect_at(66, "t4_wait_last", 3'd2, 2'd0);
    expect_at(67, "t4_retry",     3'd0, 2'd1);
    tick(67);
    usb_if_ready = 1'b1;
    push_seq(1, 2'd1);
    tick(37);

    // T5: abort beats ready at the timeout edge, then ready beats timeout
    rst = 1'b1;
    expect_at(1, "t5_rst", 3'd0, 2'd0);
    tick(1);
    rst = 1'b0; usb_if_ready = 1'b0; cfg_done = 1'b0;
    expect_at(67,  "t5_retry",      3'd0, 2'd1);
    expect_at(133, "t5_wait_last",  3'd2, 2'd1);
    expect_at(134, "t5_abort_wins", 3'd0, 2'd1);
    tick(133);
    usb_if_ready = 1'b1; usb_clk_lock = 1'b0;
    tick(1);
    usb_clk_lock = 1'b1; usb_if_ready = 1'b0;
    expect_at(66, "t5_wait_last2", 3'd2, 2'd1);
    expect_at(67, "t5_ready_wins", 3'd3, 2'd1);
    tick(66);
    usb_if_ready = 1'b1;
    tick(2);

    for (int unsigned i = 0; i < 200 && sb.size() > 0; i++) tick(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, "_unreached"}, cyc, e.at);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
